// File: rtl/key_repeat_if.sv
// key_repeat_if
//   Groups the key-path signals of one auto-repeat stage.
//   Source side (debounce + timebase) drives:
//     tick        timebase strobe, one clk wide
//     key_state   debounced key level, 1 = pressed
//     key_edge    one-cycle strobe, key_state changed this cycle
//   Repeat stage drives:
//     key_pulse   one-cycle press / auto-repeat pulse
//     key_release one-cycle debounced-release pulse
//     key_held    high while auto-repeat is active
interface key_repeat_if;
  logic tick;
  logic key_state;
  logic key_edge;
  logic key_pulse;
  logic key_release;
  logic key_held;

  modport master (
    output tick,
    output key_state,
    output key_edge,
    input  key_pulse,
    input  key_release,
    input  key_held
  );

  modport slave (
    input  tick,
    input  key_state,
    input  key_edge,
    output key_pulse,
    output key_release,
    output key_held
  );
endinterface

// File: rtl/key_repeat.sv
// key_repeat
//   Auto-repeat stage behind a key debouncer. Emits one pulse on press,
//   then after DELAY_TICKS timebase ticks a repeat pulse every RATE_TICKS
//   ticks until the key is released. All outputs are registered.
// Ports
//   i_clk   system clock, rising edge
//   i_clrn  asynchronous active-low reset
//   bus     key_repeat_if.slave: tick/key_state/key_edge in,
//           key_pulse/key_release/key_held out
module key_repeat #(
  parameter int CNT_W       = 16,
  parameter int DELAY_TICKS = 500,
  parameter int RATE_TICKS  = 100
) (
  input  logic         i_clk,
  input  logic         i_clrn,
  key_repeat_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_release;
  logic             r_held;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pulse_nxt;
  logic             w_release_nxt;
  logic             w_press;
  logic             w_rel_evt;

  assign w_press   = bus.key_edge &  bus.key_state;
  assign w_rel_evt = bus.key_edge & ~bus.key_state;

  // Next-state logic: release beats press beats tick; a tick that arrives
  // together with a press or release is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (w_rel_evt) begin
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = CNT_ZERO;
      w_release_nxt = 1'b1;
    end else if (w_press) begin
      w_state_nxt = ST_DELAY;
      w_cnt_nxt   = CNT_ZERO;
      w_pulse_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_DELAY: begin
          // key seen low without an edge: recover silently to IDLE
          if (!bus.key_state) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end else if (bus.tick) begin
            if (r_cnt == DLY_LAST) begin
              w_state_nxt = ST_REPEAT;
              w_cnt_nxt   = CNT_ZERO;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_REPEAT: begin
          if (!bus.key_state) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end else if (bus.tick) begin
            if (r_cnt == RATE_LAST) begin
              w_cnt_nxt   = CNT_ZERO;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and registered outputs; key_held mirrors the next state
  // so it rises with the first repeat pulse and falls on the exit cycle.
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= CNT_ZERO;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
      r_held    <= (w_state_nxt == ST_REPEAT);
    end
  end

  assign bus.key_pulse   = r_pulse;
  assign bus.key_release = r_release;
  assign bus.key_held    = r_held;

endmodule

// File: tb/tb_key_repeat.sv
module tb_key_repeat;
  logic clk  = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  logic r_tick = 1'b0;
  logic r_ks   = 1'b0;
  logic r_ke   = 1'b0;

  key_repeat_if u_if_a ();
  key_repeat_if u_if_b ();

  assign u_if_a.tick      = r_tick;
  assign u_if_a.key_state = r_ks;
  assign u_if_a.key_edge  = r_ke;
  assign u_if_b.tick      = r_tick;
  assign u_if_b.key_state = r_ks;
  assign u_if_b.key_edge  = r_ke;

  key_repeat #(.CNT_W(16), .DELAY_TICKS(4), .RATE_TICKS(2)) u_dut_a (
    .i_clk(clk), .i_clrn(clrn), .bus(u_if_a.slave));
  key_repeat #(.CNT_W(16), .DELAY_TICKS(1), .RATE_TICKS(1)) u_dut_b (
    .i_clk(clk), .i_clrn(clrn), .bus(u_if_b.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ticks counted since the last press while the key is down.
  int d_ticks [2] = '{4, 1};
  int r_ticks [2] = '{2, 1};
  int m_t     [2] = '{0, 0};
  bit m_act   [2] = '{1'b0, 1'b0};
  bit e_pulse [2] = '{1'b0, 1'b0};
  bit e_rel   [2] = '{1'b0, 1'b0};
  bit e_held  [2] = '{1'b0, 1'b0};

  int pulses_a = 0, pulses_b = 0, rels_a = 0, held_a_seen = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_t[k] = 0;
      e_pulse[k] = 1'b0; e_rel[k] = 1'b0; e_held[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      e_pulse[k] = 1'b0;
      e_rel[k]   = 1'b0;
      if (r_ke && !r_ks) begin
        m_act[k] = 1'b0; m_t[k] = 0; e_rel[k] = 1'b1;
      end else if (r_ke && r_ks) begin
        m_act[k] = 1'b1; m_t[k] = 0; e_pulse[k] = 1'b1;
      end else if (m_act[k] && !r_ks) begin
        m_act[k] = 1'b0; m_t[k] = 0;
      end else if (m_act[k] && r_tick) begin
        m_t[k]++;
        if (m_t[k] >= d_ticks[k] && ((m_t[k] - d_ticks[k]) % r_ticks[k]) == 0)
          e_pulse[k] = 1'b1;
      end
      e_held[k] = m_act[k] && (m_t[k] >= d_ticks[k]);
    end
  endtask

  task automatic check_all();
    check("a_pulse",   u_if_a.key_pulse,   e_pulse[0]);
    check("a_release", u_if_a.key_release, e_rel[0]);
    check("a_held",    u_if_a.key_held,    e_held[0]);
    check("b_pulse",   u_if_b.key_pulse,   e_pulse[1]);
    check("b_release", u_if_b.key_release, e_rel[1]);
    check("b_held",    u_if_b.key_held,    e_held[1]);
    if (u_if_a.key_pulse === 1'b1)   pulses_a++;
    if (u_if_b.key_pulse === 1'b1)   pulses_b++;
    if (u_if_a.key_release === 1'b1) rels_a++;
    if (u_if_a.key_held === 1'b1)    held_a_seen++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse_a"}, u_if_a.key_pulse,   1'b0);
    check({tag, "_rel_a"},   u_if_a.key_release, 1'b0);
    check({tag, "_held_a"},  u_if_a.key_held,    1'b0);
    check({tag, "_pulse_b"}, u_if_b.key_pulse,   1'b0);
    check({tag, "_held_b"},  u_if_b.key_held,    1'b0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 ns later.
  task automatic step(input logic tk, input logic ks, input logic ke);
    r_tick = tk; r_ks = ks; r_ke = ke;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic key_to(input logic ks, input logic tk);
    step(tk, ks, logic'(ks != r_ks));
  endtask

  task automatic run_clks(input int n, input int period);
    for (int i = 0; i < n; i++) step(logic'((i % period) == period - 1), r_ks, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 clrn = 1'b0;
    #1 check_zero({tag, "_async"});
    @(posedge clk);
    #1 check_zero({tag, "_held_low"});
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    #2 clrn = 1'b0;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    run_clks(5, 10);

    // 1: reset while in REPEAT, key still down afterwards
    key_to(1'b1, 1'b0);
    run_clks(60, 10);
    check("t1_in_repeat", u_if_a.key_held, 1'b1);
    pulse_reset("t1");
    pulses_a = 0;
    run_clks(40, 10);
    check_int("t1_no_pulse_after_reset", pulses_a, 0);
    key_to(1'b0, 1'b0);
    run_clks(10, 10);

    // 2: press, hold 12 ticks, release
    pulses_a = 0; rels_a = 0;
    key_to(1'b1, 1'b0);
    run_clks(120, 10);
    key_to(1'b0, 1'b0);
    run_clks(30, 10);
    check_int("t2_pulse_count", pulses_a, 6);
    check_int("t2_release_count", rels_a, 1);

    // 3: short tap of 3 ticks
    pulses_a = 0; rels_a = 0; held_a_seen = 0;
    key_to(1'b1, 1'b0);
    run_clks(30, 10);
    key_to(1'b0, 1'b0);
    run_clks(20, 10);
    check_int("t3_pulse_count", pulses_a, 1);
    check_int("t3_release_count", rels_a, 1);
    check_int("t3_held_seen", held_a_seen, 0);

    // 4: press with a tick, release with the 4th tick
    pulses_a = 0; rels_a = 0;
    key_to(1'b1, 1'b1);
    run_clks(30, 10);
    key_to(1'b0, 1'b1);
    run_clks(20, 10);
    check_int("t4_pulse_count", pulses_a, 1);
    check_int("t4_release_count", rels_a, 1);

    // 5: DELAY=RATE=1 instance, tick every clk, hold 5 clk
    pulses_b = 0;
    key_to(1'b1, 1'b1);
    run_clks(5, 1);
    key_to(1'b0, 1'b1);
    run_clks(5, 1);
    check_int("t5_pulse_count", pulses_b, 6);

    // 6: key level drops in REPEAT without an edge
    key_to(1'b1, 1'b0);
    run_clks(60, 10);
    check("t6_in_repeat", u_if_a.key_held, 1'b1);
    pulses_a = 0; rels_a = 0;
    step(1'b0, 1'b0, 1'b0);
    check("t6_held_dropped", u_if_a.key_held, 1'b0);
    run_clks(40, 10);
    check_int("t6_pulses", pulses_a, 0);
    check_int("t6_releases", rels_a, 0);

    // randomized traffic: ticks, presses, releases, re-presses, silent drops
    for (int i = 0; i < 800; i++) begin
      logic tk, ks, ke;
      int  r;
      tk = logic'($urandom_range(0, 2) == 0);
      ks = r_ks;
      ke = 1'b0;
      r  = $urandom_range(0, 99);
      if (r < 6) begin
        ks = ~r_ks; ke = 1'b1;
      end else if (r < 7 && r_ks) begin
        ks = 1'b1; ke = 1'b1;
      end else if (r < 8 && r_ks) begin
        ks = 1'b0; ke = 1'b0;
      end
      step(tk, ks, ke);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
